// File: rtl/dac1411_tx_pkg.sv
// Shared constants for the DAC transmit path: IAGC status codes and the
// state encoding of the transmit sequencer.
package dac1411_tx_pkg;

  localparam logic [3:0] IAGC_STATUS_RESET  = 4'h0;
  localparam logic [3:0] IAGC_STATUS_SAMPLE = 4'h3;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } dac_state_t;

endpackage

// File: rtl/dac1411_tx_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding packed sample pairs.
// rd_data always shows the oldest entry; pop simply advances past it.
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] COUNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == COUNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dac1411_tx.sv
// Transmit path to the two-channel 14-bit DAC: buffers signed sample pairs,
// sequences the DAC power-up reset, and streams ch1/ch2 words at a
// programmable period while the IAGC core reports SAMPLE.
module dac1411_tx
  import dac1411_tx_pkg::*;
#(
  parameter int DATA_SIZE        = 14,
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int RATE_DIV_SIZE    = 16,
  parameter int INIT_CYCLES      = 1000
) (
  input  logic                          i_sys_clock,
  input  logic                          i_reset,
  input  logic [IAGC_STATUS_SIZE-1:0]   i_iagc_status,
  input  logic [RATE_DIV_SIZE-1:0]      i_rate_div,
  input  logic [DATA_SIZE-1:0]          i_sample_ch1,
  input  logic [DATA_SIZE-1:0]          i_sample_ch2,
  input  logic                          i_sample_valid,
  output logic                          o_sample_ready,
  output logic [DATA_SIZE-1:0]          o_dac_data,
  output logic                          o_dac_sel,
  output logic                          o_dac_wrt,
  output logic                          o_dac_rst,
  output logic                          o_dac_init_done,
  output logic                          o_underflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
  localparam logic [RATE_DIV_SIZE:0] CNT_ONE = (RATE_DIV_SIZE+1)'(1);
  localparam logic [DATA_SIZE-1:0] MIDSCALE = {1'b1, {(DATA_SIZE-1){1'b0}}};
  localparam logic [IAGC_STATUS_SIZE-1:0] STATUS_RESET  = IAGC_STATUS_SIZE'(IAGC_STATUS_RESET);
  localparam logic [IAGC_STATUS_SIZE-1:0] STATUS_SAMPLE = IAGC_STATUS_SIZE'(IAGC_STATUS_SAMPLE);

  dac_state_t                state;
  logic [INIT_W-1:0]         init_cnt;
  logic [RATE_DIV_SIZE:0]    cnt;
  logic [RATE_DIV_SIZE-1:0]  rate_div_q;
  logic [RATE_DIV_SIZE:0]    period_last;
  logic [2*DATA_SIZE-1:0]    last_pair;
  logic [2*DATA_SIZE-1:0]    fifo_rd;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      soft_reset;
  logic                      sampling;
  logic                      push;
  logic                      pop;

  assign soft_reset  = (i_iagc_status == STATUS_RESET);
  assign sampling    = (i_iagc_status == STATUS_SAMPLE);
  assign period_last = {1'b0, rate_div_q} + CNT_ONE;
  assign push        = i_sample_valid && !fifo_full && (state != ST_INIT);
  assign pop         = (state == ST_RUN) && (cnt == '0) && !fifo_empty && !soft_reset && !i_reset;

  assign o_sample_ready = !fifo_full;

  sync_fifo #(
    .WIDTH (2*DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (i_sys_clock),
    .reset   (i_reset),
    .push    (push),
    .pop     (pop),
    .wr_data ({i_sample_ch1, i_sample_ch2}),
    .rd_data (fifo_rd),
    .count   (o_fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sequencer: DAC reset hold, idle midscale, and the per-period ch1/ch2 write pattern.
  always_ff @(posedge i_sys_clock) begin
    if (i_reset || soft_reset) begin
      state           <= ST_INIT;
      init_cnt        <= '0;
      cnt             <= '0;
      rate_div_q      <= '0;
      last_pair       <= '0;
      o_dac_data      <= MIDSCALE;
      o_dac_sel       <= 1'b0;
      o_dac_wrt       <= 1'b0;
      o_dac_rst       <= 1'b1;
      o_dac_init_done <= 1'b0;
      o_underflow     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          o_dac_wrt <= 1'b0;
          if (init_cnt == INIT_LAST) begin
            state           <= ST_IDLE;
            o_dac_rst       <= 1'b0;
            o_dac_init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + INIT_ONE;
          end
        end
        ST_IDLE: begin
          o_dac_data <= MIDSCALE;
          o_dac_sel  <= 1'b0;
          o_dac_wrt  <= 1'b0;
          if (sampling) begin
            state       <= ST_RUN;
            cnt         <= '0;
            o_underflow <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt == '0) begin
            rate_div_q <= i_rate_div;
            cnt        <= CNT_ONE;
            o_dac_sel  <= 1'b0;
            o_dac_wrt  <= 1'b1;
            if (!fifo_empty) begin
              last_pair  <= fifo_rd;
              o_dac_data <= fifo_rd[2*DATA_SIZE-1 -: DATA_SIZE] ^ MIDSCALE;
            end else begin
              o_dac_data  <= last_pair[2*DATA_SIZE-1 -: DATA_SIZE] ^ MIDSCALE;
              o_underflow <= 1'b1;
            end
          end else begin
            if (cnt == CNT_ONE) begin
              o_dac_data <= last_pair[DATA_SIZE-1:0] ^ MIDSCALE;
              o_dac_sel  <= 1'b1;
              o_dac_wrt  <= 1'b1;
            end else begin
              o_dac_wrt <= 1'b0;
            end
            if (!sampling) begin
              state <= ST_IDLE;
            end else if (cnt == period_last) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule
